// File: rtl/uart_pkg.sv
// uart_pkg: FSM state encoding, CR/LF bytes and default timing constants shared by uart_tx_feeder and uart_sync_fifo
package uart_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PULSE, S_ARM, S_BUSY, S_GAP} state_t;
  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;
  localparam int DEF_FIFO_AW = 4;
  localparam int DEF_PULSE_LEN = 2;
  localparam int DEF_GAP_CYCLES = 16;
  localparam int DEF_START_TIMEOUT = 64;
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: synchronous FIFO, 2**AW x W; ports clk rst push din pop dout(head) count full(registered) empty
module uart_sync_fifo import uart_pkg::*; #(
  parameter int W = 8,
  parameter int AW = DEF_FIFO_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);
  localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);
  logic [W-1:0] mem [2**AW];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  logic [AW:0] count_n;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign count_n = count + (AW+1)'(do_push) - (AW+1)'(do_pop);
  assign empty = count == '0;
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      full <= 1'b0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      count <= count_n;
      full <= count_n == DEPTH;
    end
endmodule

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: FIFO-buffered byte launcher for the UART transmitter (in_* push side, tx_data0/tx_int launch, bps_start busy input, busy/fifo_count/start_err status, err_clr); optional CR/LF insertion after in_last bytes with UART_TX_FEEDER_CRLF_EN
module uart_tx_feeder import uart_pkg::*; #(
  parameter int FIFO_AW = DEF_FIFO_AW,
  parameter int PULSE_LEN = DEF_PULSE_LEN,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int START_TIMEOUT = DEF_START_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  input  logic               in_last,
  output logic               in_ready,
  output logic [7:0]         tx_data0,
  output logic               tx_int,
  input  logic               bps_start,
  output logic               busy,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               start_err,
  input  logic               err_clr
);
`ifdef UART_TX_FEEDER_CRLF_EN
  localparam int W = 9;
`else
  localparam int W = 8;
`endif
  localparam logic [15:0] PL = 16'(PULSE_LEN);
  localparam logic [15:0] GL = 16'(GAP_CYCLES);
  localparam logic [15:0] TL = 16'(START_TIMEOUT);
  localparam state_t POST = GAP_CYCLES == 0 ? S_IDLE : S_GAP;
  state_t state, nxt;
  logic [15:0] cnt;
  logic [W-1:0] din, head;
  logic [1:0] ins;
  logic full, empty, pop, timeout;
  logic [7:0] ld_byte;
  assign in_ready = ~full;
  uart_sync_fifo #(.W(W), .AW(FIFO_AW)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(in_valid),
    .din(din),
    .pop(pop),
    .dout(head),
    .count(fifo_count),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk)
    if (rst) state <= S_IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  nxt = (!empty || ins != 2'd0) ? S_LOAD : S_IDLE;
      S_LOAD:  nxt = S_PULSE;
      S_PULSE: nxt = cnt >= PL ? S_ARM : S_PULSE;
      S_ARM:   nxt = bps_start ? S_BUSY : timeout ? POST : S_ARM;
      S_BUSY:  nxt = bps_start ? S_BUSY : POST;
      S_GAP:   nxt = cnt == GL - 16'd1 ? S_IDLE : S_GAP;
      default: nxt = S_IDLE;
    endcase
  end
  always_comb begin
    pop = state == S_LOAD && ins == 2'd0;
    busy = state != S_IDLE || !empty || ins != 2'd0;
    ld_byte = ins == 2'd1 ? CR : ins == 2'd2 ? LF : head[7:0];
    timeout = state == S_ARM && !bps_start && cnt == TL - 16'd1;
  end
  // cnt restarts on every state change; PULSE starts at 1 so the LOAD edge counts toward PULSE_LEN
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      tx_data0 <= '0;
      tx_int <= 1'b0;
      start_err <= 1'b0;
    end else begin
      cnt <= nxt != state ? (state == S_LOAD ? 16'd1 : 16'd0) : cnt + 16'd1;
      tx_int <= nxt == S_PULSE;
      if (state == S_LOAD) tx_data0 <= ld_byte;
      start_err <= timeout | (start_err & ~err_clr);
    end
`ifdef UART_TX_FEEDER_CRLF_EN
  // ins: 1 = CR owed, 2 = LF owed; cur_last marks the FIFO byte currently in flight
  logic cur_last;
  assign din = {in_last, in_data};
  always_ff @(posedge clk)
    if (rst) begin
      ins <= 2'd0;
      cur_last <= 1'b0;
    end else if (state == S_LOAD) begin
      ins <= ins == 2'd1 ? 2'd2 : 2'd0;
      cur_last <= ins == 2'd0 && head[8];
    end else if (state == S_BUSY && !bps_start && cur_last) ins <= 2'd1;
`else
  logic unused_last;
  assign din = in_data;
  assign ins = 2'd0;
  assign unused_last = in_last;
`endif
endmodule
